// File: rtl/irq_dispatch_pkg.sv
// Shared definitions for the interrupt dispatcher: FSM state codes and a
// constant-foldable ceiling-log2 used to size counters.
package irq_dispatch_pkg;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE    = 2'd0;
    localparam state_t ST_REQ     = 2'd1;
    localparam state_t ST_SERVICE = 2'd2;

    // Smallest n with 2**n >= val; clog2(0) = clog2(1) = 0.
    function automatic int unsigned clog2(input int unsigned val);
        int unsigned res;
        res = 0;
        for (int i = 0; i < 32; i++) begin
            if ((64'd1 << i) < 64'(val)) begin
                res = 32'(i) + 32'd1;
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/irq_rr_arb.sv
// Combinational round-robin arbiter: grants the first request found scanning
// upward from last_i+1, wrapping at NUM_IRQ (which need not be a power of two).
module irq_rr_arb
    import irq_dispatch_pkg::*;
#(
    parameter int unsigned NUM_IRQ   = 8,
    parameter int unsigned VEC_WIDTH = 3
) (
    input  logic [NUM_IRQ-1:0]   req_i,
    input  logic [VEC_WIDTH-1:0] last_i,
    output logic                 grant_vld_o,
    output logic [VEC_WIDTH-1:0] grant_idx_o
);

    logic [2*NUM_IRQ-1:0] req_dbl;
    logic [NUM_IRQ-1:0]   rot;
    logic                 found;
    int unsigned          start;
    int unsigned          ffs;
    int unsigned          idx;

    // Rotate so the scan start sits at bit 0, find first set, rotate the index back.
    always_comb begin
        start   = (32'(last_i) >= NUM_IRQ - 1) ? 32'd0 : 32'(last_i) + 32'd1;
        // Doubling the vector makes a plain right shift act as a modulo-NUM_IRQ rotate.
        req_dbl = {req_i, req_i};
        rot     = NUM_IRQ'(req_dbl >> start);
        found   = 1'b0;
        ffs     = 32'd0;
        for (int i = 0; i < NUM_IRQ; i++) begin
            if (!found && rot[i]) begin
                found = 1'b1;
                ffs   = 32'(i);
            end
        end
        idx = start + ffs;
        if (idx >= NUM_IRQ) begin
            idx = idx - NUM_IRQ;
        end
    end

    assign grant_vld_o = found;
    assign grant_idx_o = VEC_WIDTH'(idx);

endmodule

// File: rtl/irq_dispatch.sv
// Round-robin interrupt dispatcher: presents one eligible level IRQ at a time
// to the CPU on a req/ack handshake and holds it in service until EOI.
module irq_dispatch
    import irq_dispatch_pkg::*;
#(
    parameter int unsigned NUM_IRQ     = 8,
    parameter int unsigned VEC_WIDTH   = 3,
    parameter int unsigned ACK_TIMEOUT = 0
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic [NUM_IRQ-1:0]   irq_i,
    input  logic [NUM_IRQ-1:0]   enable_i,
    output logic                 cpu_req_o,
    output logic [VEC_WIDTH-1:0] cpu_vec_o,
    input  logic                 cpu_ack_i,
    input  logic                 cpu_eoi_i,
    output logic                 busy_o,
    output logic                 spurious_o,
    output logic                 timeout_o
);

    localparam int unsigned TimerW = (ACK_TIMEOUT == 0) ? 1 : clog2(ACK_TIMEOUT + 1);
    // Only consulted when ACK_TIMEOUT != 0, so the wrap at zero is harmless.
    localparam logic [TimerW-1:0] TimerLast = TimerW'(ACK_TIMEOUT - 1);
    localparam logic [TimerW-1:0] TimerMax  = '1;

    state_t               state_q, state_d;
    logic [VEC_WIDTH-1:0] vec_q, vec_d;
    logic [VEC_WIDTH-1:0] last_q, last_d;
    logic [TimerW-1:0]    timer_q, timer_d;
    logic                 req_q, req_d;
    logic                 busy_q;
    logic                 spur_q, spur_d;
    logic                 tmo_q, tmo_d;

    logic [NUM_IRQ-1:0]   eligible;
    logic                 cur_elig;
    logic                 grant_vld;
    logic [VEC_WIDTH-1:0] grant_idx;

    assign eligible = irq_i & enable_i;

    // Look up whether the source currently on cpu_vec is still asking.
    always_comb begin
        cur_elig = 1'b0;
        for (int i = 0; i < NUM_IRQ; i++) begin
            if (VEC_WIDTH'(i) == vec_q) begin
                cur_elig = eligible[i];
            end
        end
    end

    irq_rr_arb #(
        .NUM_IRQ   (NUM_IRQ),
        .VEC_WIDTH (VEC_WIDTH)
    ) u_arb (
        .req_i       (eligible),
        .last_i      (last_q),
        .grant_vld_o (grant_vld),
        .grant_idx_o (grant_idx)
    );

    // Next-state logic for the dispatch FSM, timer and round-robin pointer.
    always_comb begin
        state_d = state_q;
        vec_d   = vec_q;
        last_d  = last_q;
        timer_d = timer_q;
        req_d   = req_q;
        spur_d  = 1'b0;
        tmo_d   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (grant_vld) begin
                    vec_d   = grant_idx;
                    req_d   = 1'b1;
                    timer_d = '0;
                    state_d = ST_REQ;
                end
            end
            ST_REQ: begin
                // Ack has priority over withdrawal and timeout in the same cycle.
                if (cpu_ack_i) begin
                    req_d   = 1'b0;
                    last_d  = vec_q;
                    state_d = ST_SERVICE;
                end else if (!cur_elig) begin
                    req_d   = 1'b0;
                    spur_d  = 1'b1;
                    state_d = ST_IDLE;
                end else if ((ACK_TIMEOUT != 0) && (timer_q == TimerLast)) begin
                    // Advance the pointer so an unresponsive CPU cannot pin one source.
                    req_d   = 1'b0;
                    tmo_d   = 1'b1;
                    last_d  = vec_q;
                    state_d = ST_IDLE;
                end else if (timer_q != TimerMax) begin
                    timer_d = timer_q + TimerW'(1);
                end
            end
            ST_SERVICE: begin
                if (cpu_eoi_i) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                req_d   = 1'b0;
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and registered outputs.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= ST_IDLE;
            vec_q   <= '0;
            last_q  <= VEC_WIDTH'(NUM_IRQ - 1);
            timer_q <= '0;
            req_q   <= 1'b0;
            busy_q  <= 1'b0;
            spur_q  <= 1'b0;
            tmo_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            vec_q   <= vec_d;
            last_q  <= last_d;
            timer_q <= timer_d;
            req_q   <= req_d;
            busy_q  <= (state_d != ST_IDLE);
            spur_q  <= spur_d;
            tmo_q   <= tmo_d;
        end
    end

    assign cpu_req_o  = req_q;
    assign cpu_vec_o  = vec_q;
    assign busy_o     = busy_q;
    assign spurious_o = spur_q;
    assign timeout_o  = tmo_q;

endmodule
